serial_adder: RTL
=================

# serial_adder

- Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- A single full-adder cell iterates over the operand; a small FSM drives it with a start/busy/done handshake.
- Serves as the area-minimal multi-bit adder in the arithmetic library, beside the combinational half and full adders.

## Interface
- WIDTH, 8: operand and result width in bits (≥1).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on an accepted start.
- b  input  WIDTH  operand B; sampled on an accepted start.
- cin  input  1  carry-in; sampled on an accepted start.
- sub  input  1  subtract select; sampled on an accepted start. Present only when SERIAL_ADDER_SUB_EN is defined.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result; held from done until the next accepted start or reset.
- carry  output  1  final carry-out; held with sum.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE after WIDTH bit-steps.
  - DONE→RUN on start, else DONE→IDLE.
- Accepted start (IDLE or DONE):
  - Latch a and b into shift registers and cin into the carry flop.
  - Clear sum and the bit counter.
- Each RUN cycle:
  - Full adder combines a_sh[0], b_sh[0] and the carry flop.
  - Sum bit shifts into sum[WIDTH-1] while sum shifts right.
  - New carry is stored; a_sh and b_sh shift right; the counter increments.
- Counter width is $clog2(WIDTH+1). When it reaches WIDTH-1 during RUN, the next state is DONE.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- start while RUN is ignored and the operation continues unaffected. Operand changes after acceptance have no effect.
- reset at any time, including mid-RUN:
  - Next state is IDLE.
  - busy, done, sum and carry all read 0 in the following cycle.
  - Any partial result is discarded.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, carry 0.
- Start sampled high at edge E0: busy is 1 from E0 through E_WIDTH (WIDTH cycles).
- done is 1 for the single cycle after edge E_WIDTH. Latency from start sample to done is WIDTH+1 edges.
- sum and carry are stable and valid from the done cycle onward.
- Back-to-back operation: start high during the done cycle is accepted, giving throughput of one result per WIDTH+1 cycles.
  - busy rises again at the next edge.
  - done deasserts at that same edge.
  - sum and carry clear at that same edge.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub port exists.
  - If sub=1 on start, latch ~b and force the carry flop to 1, ignoring cin. Result is a − b; carry=1 means no borrow.
  - sub=0 behaves as plain addition.
- SERIAL_ADDER_SUB_EN undefined: no sub port, add-only; behaviour is identical to sub=0.

## Structure
- Package serial_adder_pkg:
  - state_e enum: IDLE, RUN, DONE (2-bit encoding).
  - CNT_W helper function: $clog2(WIDTH+1).
- Sub-module full_adder: ports a, b, cin → sum, cout. Built from two half adders plus an OR. Instantiated once.
- Top level holds the FSM, counter, shift registers and carry flop.

## Test plan (WIDTH=8)
- Reset, then a=0x00, b=0x00, cin=0 → done 9 edges after start; sum=0x00, carry=0; busy high exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, carry=1. Then a=0x5A, b=0xA5, cin=1 → sum=0x00, carry=1.
- start pulsed again mid-RUN with a=0x11, b=0x22 → ignored; original result delivered on schedule; no extra done pulse.
- reset asserted at the 4th RUN cycle → next cycle IDLE, busy=0, sum=0x00, carry=0; no done pulse follows.
- start held high through the done cycle:
  - 0x01+0x01 returns sum=0x02.
  - 0x80+0x80 is accepted immediately and returns sum=0x00, carry=1.
  - The two done pulses are 9 cycles apart.
- SERIAL_ADDER_SUB_EN defined: sub=1, 0x10−0x01 → sum=0x0F, carry=1; 0x01−0x02 → sum=0xFF, carry=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg -- shared types and helpers for the bit-serial adder.
//   state_e : FSM state encoding (IDLE, RUN, DONE), 2 bits.
//   CNT_W   : width of the bit-step counter for a given operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold values 0..WIDTH.
  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// full_adder -- one-bit full adder built from two half adders and an OR.
// Ports:
//   a, b, cin : input bits
//   sum, cout : sum bit and carry-out
// half_adder is the building block used twice inside full_adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule : half_adder

module full_adder
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0_s;
  logic c0_s;
  logic c1_s;

  half_adder u_ha0 (.a(a),    .b(b),   .s(s0_s), .c(c0_s));
  half_adder u_ha1 (.a(s0_s), .b(cin), .s(sum),  .c(c1_s));

  assign cout = c0_s | c1_s;
endmodule : full_adder

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial adder: {carry,sum} = a + b + cin, one bit per
// clock, LSB first, using a single full_adder cell.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the 'sub' port
// (sub=1 computes a - b; carry=1 means no borrow).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   start : request, honoured only in IDLE or DONE
//   a, b  : WIDTH-bit operands, captured on an accepted start
//   cin   : carry-in, captured on an accepted start
//   sub   : subtract select (SERIAL_ADDER_SUB_EN only)
//   busy  : high while the bit steps are running
//   done  : one-cycle pulse when sum/carry become valid
//   sum   : WIDTH-bit result, held until next accepted start or reset
//   carry : final carry-out, held with sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = CNT_W(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             cflop_q;   // running carry between bit steps
  logic             carry_q;   // carry-out as presented on the port
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] b_load_d;
  logic             cin_load_d;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (cflop_q),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Next sum register: shift right, new bit enters at the MSB.
  always_comb begin
    sum_d            = sum_q >> 1;
    sum_d[WIDTH-1]   = fa_sum_s;
  end

  // Operand-B and carry values captured on an accepted start.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; cin is ignored in that mode.
    if (sub) begin
      b_load_d   = ~b;
      cin_load_d = 1'b1;
    end else begin
      b_load_d   = b;
      cin_load_d = cin;
    end
`else
    b_load_d   = b;
    cin_load_d = cin;
`endif
  end

  // FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cflop_q <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b_load_d;
            cflop_q <= cin_load_d;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately ignored here.
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          sum_q   <= sum_d;
          cflop_q <= fa_cout_s;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            carry_q <= fa_cout_s;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule : serial_adder
